lsu_mem_master: RTL and testbench
=================================

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter MEM_DEPTH, default 8, number of valid data-memory words; addresses >= MEM_DEPTH are out of range.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  pipeline presents a load/store command.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_is_store  input  1  1 = store, 0 = load.
REQ-007 cmd_base  input  8  base address operand.
REQ-008 cmd_offset  input  8  offset operand.
REQ-009 cmd_wdata  input  8  store data.
REQ-010 cmd_rd  input  3  destination register tag, returned with the response.
REQ-011 mem_read  output  1  read strobe to data memory.
REQ-012 mem_write  output  1  write strobe to data memory.
REQ-013 mem_addr  output  8  data-memory address.
REQ-014 mem_wdata  output  8  data-memory write data.
REQ-015 mem_rdata  input  8  data-memory read data, registered by memory on the strobe edge.
REQ-016 rsp_valid  output  1  response available.
REQ-017 rsp_ready  input  1  consumer accepts the response.
REQ-018 rsp_data  output  8  load data; 0 for stores and errors.
REQ-019 rsp_rd  output  3  tag of the completed command.
REQ-020 rsp_err  output  1  1 = address out of range.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT, RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on an edge where cmd_valid=1 and cmd_ready=1.
REQ-023 On acceptance, the block SHALL register the type, wdata and rd, and SHALL compute addr = (cmd_base + cmd_offset) mod 256; the carry SHALL be discarded.
REQ-024 The FSM SHALL go IDLE->ACCESS on acceptance.
REQ-025 In ACCESS with an in-range address, the block SHALL assert exactly one of mem_read or mem_write for exactly one cycle, with mem_addr = addr and mem_wdata = the registered wdata.
REQ-026 In ACCESS with an out-of-range address, the block SHALL assert neither strobe; it SHALL go ACCESS->RESP with rsp_err=1 and rsp_data=0.
REQ-027 An in-range store SHALL go ACCESS->RESP with rsp_err=0 and rsp_data=0.
REQ-028 An in-range load SHALL go ACCESS->WAIT; in WAIT, mem_rdata SHALL be captured into rsp_data, then the FSM SHALL go WAIT->RESP.
REQ-029 Latency SHALL be fixed:
- Load: rsp_valid rises 3 edges after acceptance.
- Store or error: rsp_valid rises 2 edges after acceptance.
REQ-030 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_rd and rsp_err SHALL be held stable until an edge with rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-031 rsp_ready high while not in RESP SHALL be ignored.
REQ-032 Outside ACCESS, mem_read and mem_write SHALL be 0; no command SHALL produce more than one strobe.
REQ-033 cmd_valid and other command inputs SHALL be ignored outside IDLE; there SHALL be no queuing.

Reset
REQ-034 While reset=0, irrespective of clk, the block SHALL hold:
- state IDLE.
- cmd_ready=0.
- mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0.
REQ-035 cmd_ready SHALL be 1 from the first edge after reset deasserts.
REQ-036 Reset asserted in any non-IDLE state SHALL abort the command: no strobe and no response shall follow.

Verification (memory model: word i = i after reset, MEM_DEPTH=8)
REQ-037 Load, base=0x03, offset=0x02, rd=4 -> one-cycle mem_read, mem_addr=0x05; rsp_valid 3 edges after accept with rsp_data=0x05, rsp_rd=4, rsp_err=0.
REQ-038 Store, base=0x01, offset=0x00, wdata=0xAA, then load of addr 0x01 -> one-cycle mem_write, mem_addr=0x01; store response after 2 edges; load returns rsp_data=0xAA.
REQ-039 Wrap: load, base=0xFE, offset=0x03 -> mem_addr=0x01, rsp_data=0x01, rsp_err=0.
REQ-040 Out of range: load, base=0x10, offset=0x00 -> no strobe; rsp_err=1, rsp_data=0, response after 2 edges.
REQ-041 Backpressure: rsp_ready=0 for 4 cycles with cmd_valid held high -> rsp_valid and rsp_data stable, cmd_ready=0, no further strobe; rsp_ready=1 -> IDLE on that edge.
REQ-042 Reset pulse during WAIT of a load -> all outputs 0 immediately, no response; after release, a load of addr 0x07 returns 0x07.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// rtl/lsu_mem_master_if.sv - Command, data-memory and response signal bundle for lsu_mem_master
interface lsu_mem_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_is_store;
  logic [7:0] cmd_base;
  logic [7:0] cmd_offset;
  logic [7:0] cmd_wdata;
  logic [2:0] cmd_rd;

  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_rd;
  logic       rsp_err;

  modport master (
    input  cmd_valid, cmd_is_store, cmd_base, cmd_offset, cmd_wdata, cmd_rd,
    input  mem_rdata, rsp_ready,
    output cmd_ready, mem_read, mem_write, mem_addr, mem_wdata,
    output rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_is_store, cmd_base, cmd_offset, cmd_wdata, cmd_rd,
    output mem_rdata, rsp_ready,
    input  cmd_ready, mem_read, mem_write, mem_addr, mem_wdata,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err
  );
endinterface

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - Single-outstanding load/store unit driving a one-cycle-strobe data memory
module lsu_mem_master #(
  parameter int MEM_DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

  state_t     state;
  state_t     state_nxt;
  logic       armed;
  logic       accept;
  logic [7:0] addr_sum;
  logic       is_store_q;
  logic       err_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic [2:0] rd_q;

  // Carry out of the 8-bit add is dropped on purpose: addresses wrap mod 256.
  assign addr_sum = bus.cmd_base + bus.cmd_offset;
  assign accept   = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = armed;
        if (accept) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_read  = !err_q && !is_store_q;
        bus.mem_write = !err_q && is_store_q;
        state_nxt     = (err_q || is_store_q) ? RESP : WAIT;
      end
      WAIT: begin
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Response fields only change on acceptance or load capture, so they stay put in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      rd_q       <= 3'd0;
    end else if (accept) begin
      is_store_q <= bus.cmd_is_store;
      err_q      <= ({1'b0, addr_sum} >= DEPTH_LIM);
      addr_q     <= addr_sum;
      wdata_q    <= bus.cmd_wdata;
      rdata_q    <= 8'h00;
      rd_q       <= bus.cmd_rd;
    end else if (state == WAIT) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - Randomized and directed checks of lsu_mem_master against a transaction-level model
module tb_lsu_mem_master;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  lsu_mem_master_if bus();

  lsu_mem_master #(.MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory: word i holds i after reset, read data registered on the strobe edge.
  logic [7:0] mem [DEPTH];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
      bus.mem_rdata <= 8'h00;
    end else begin
      if (bus.mem_write && bus.mem_addr < DEPTH) mem[bus.mem_addr[2:0]] <= bus.mem_wdata;
      if (bus.mem_read && bus.mem_addr < DEPTH) bus.mem_rdata <= mem[bus.mem_addr[2:0]];
    end
  end

  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  always @(negedge clk) begin
    if (bus.mem_read)  rd_cnt++;
    if (bus.mem_write) wr_cnt++;
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (bus.mem_read || bus.mem_write) last_addr = bus.mem_addr;
  end

  logic [7:0] ref_mem [DEPTH];

  function automatic logic [31:0] all_outputs();
    return {bus.cmd_ready, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata,
            bus.rsp_valid, bus.rsp_data, bus.rsp_rd, bus.rsp_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i);
  endtask

  task automatic run_cmd(input bit st, input logic [7:0] base, input logic [7:0] off,
                         input logic [7:0] wd, input logic [2:0] rd, input int stall,
                         input bit hold_valid);
    logic [7:0] addr;
    bit         in_rng;
    int         exp_lat, lat, rd0, wr0, bth0, waits;
    logic [7:0] exp_data;
    addr     = base + off;
    in_rng   = (addr < DEPTH);
    exp_lat  = (st || !in_rng) ? 2 : 3;
    exp_data = (!st && in_rng) ? ref_mem[addr[2:0]] : 8'h00;

    waits = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check("cmd_ready_before_accept", 32'(bus.cmd_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt; bth0 = both_cnt;
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_store = st;
    bus.cmd_base     = base;
    bus.cmd_offset   = off;
    bus.cmd_wdata    = wd;
    bus.cmd_rd       = rd;
    bus.rsp_ready    = 1'($urandom);
    @(posedge clk);
    #1;
    if (!hold_valid) bus.cmd_valid = 1'b0;
    bus.cmd_is_store = 1'($urandom);
    bus.cmd_base     = 8'($urandom);
    bus.cmd_wdata    = 8'($urandom);
    bus.cmd_rd       = 3'($urandom);

    lat = 1;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid || lat > 8) break;
      @(posedge clk);
      lat++;
    end
    bus.rsp_ready = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    check("rsp_rd", 32'(bus.rsp_rd), 32'(rd));
    check("rsp_err", 32'(bus.rsp_err), 32'(!in_rng));

    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_rsp", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rd, bus.rsp_data},
            {1'b0, 1'b1, !in_rng, rd, exp_data});
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("back_to_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    check("read_strobes", 32'(rd_cnt - rd0), 32'(!st && in_rng));
    check("write_strobes", 32'(wr_cnt - wr0), 32'(st && in_rng));
    check("dual_strobe", 32'(both_cnt - bth0), 32'd0);
    if (in_rng) check("strobe_addr", 32'(last_addr), 32'(addr));

    if (st && in_rng) ref_mem[addr[2:0]] = wd;
  endtask

  initial begin
    int         rd0, wr0;
    bit         st;
    logic [7:0] base, off, target;

    bus.cmd_valid    = 1'b0;
    bus.cmd_is_store = 1'b0;
    bus.cmd_base     = 8'h00;
    bus.cmd_offset   = 8'h00;
    bus.cmd_wdata    = 8'h00;
    bus.cmd_rd       = 3'd0;
    bus.rsp_ready    = 1'b0;
    ref_reset();

    #2;
    check("reset_outputs", all_outputs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_clocked", all_outputs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(bus.cmd_ready), 32'd1);

    run_cmd(1'b0, 8'h03, 8'h02, 8'h00, 3'd4, 0, 1'b0);
    run_cmd(1'b1, 8'h01, 8'h00, 8'hAA, 3'd2, 0, 1'b0);
    run_cmd(1'b0, 8'h01, 8'h00, 8'h00, 3'd3, 1, 1'b0);
    run_cmd(1'b0, 8'hFE, 8'h03, 8'h00, 3'd1, 0, 1'b0);
    run_cmd(1'b0, 8'h10, 8'h00, 8'h00, 3'd6, 0, 1'b0);
    run_cmd(1'b1, 8'h04, 8'h04, 8'h5C, 3'd7, 0, 1'b0);
    run_cmd(1'b0, 8'h02, 8'h00, 8'h00, 3'd5, 4, 1'b1);

    for (int n = 0; n < 40; n++) begin
      st     = 1'($urandom);
      base   = 8'($urandom);
      target = 8'($urandom_range(0, 9));
      off    = ($urandom_range(0, 3) != 0) ? 8'(target - base) : 8'($urandom);
      run_cmd(st, base, off, 8'($urandom), 3'($urandom), $urandom_range(0, 2),
              1'($urandom));
    end

    // Abort a load while it waits for memory data.
    @(negedge clk);
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_store = 1'b0;
    bus.cmd_base     = 8'h05;
    bus.cmd_offset   = 8'h00;
    bus.cmd_rd       = 3'd2;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_outputs", all_outputs(), 32'd0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    repeat (2) begin
      @(negedge clk);
      check("abort_held", {bus.rsp_valid, bus.cmd_ready}, 2'b00);
    end
    reset = 1'b1;
    ref_reset();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("abort_no_strobe", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
    run_cmd(1'b0, 8'h07, 8'h00, 8'h00, 3'd3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
